load_store_unit: RTL and testbench

//  Multi-cycle data-memory interface between the single-cycle datapath and a req/ready data bus.
//  - Datapath side: consumes the address and store data (Mem_WrAddr / Mem_WrData) and returns
//    the load result (ReadData). Holds the core via ls_stall while a bus access is in flight.
//  - Handles RV32I byte/half/word lane steering, store strobes and load sign/zero extension.
//  - Rejects misaligned accesses and illegal funct3 codes before they reach the bus.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory interface between the single-cycle
// datapath and a req/ready data bus. Steers byte/half/word lanes, generates
// store strobes, sign/zero-extends loads and rejects misaligned or illegal
// accesses before they reach the bus.
//
// Optional feature: define LSU_TIMEOUT_EN to build a bus-wait counter that
// abandons an access after TIMEOUT_CYCLES wait cycles and raises ls_fault.
//
// state | meaning
// IDLE  | waiting for a load/store; illegal requests fault here with no bus access
// REQ   | bus request held with stable address/data until mem_ready (or timeout)
// DONE  | access finished; ls_rdata valid, core released on this edge
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ls_valid,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_stall,
  output logic        ls_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        fault_q;
  logic        funct3_ok;
  logic        misaligned;
  logic        legal;
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;

  // Out-of-range timeout values are rejected at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be in 1..65535");
  end

  // Legality of the incoming request: funct3 code and natural alignment.
  always_comb begin
    funct3_ok = 1'b0;
    case (ls_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !ls_we;
      default:                funct3_ok = 1'b0;
    endcase
    misaligned = ((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
                 ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
    legal = funct3_ok && !misaligned;
  end

  // Store lane steering: strobes shifted to the byte offset, data replicated.
  always_comb begin
    strb_next  = 4'b0000;
    wdata_next = ls_wdata;
    case (ls_funct3[1:0])
      2'b00: begin
        strb_next  = 4'b0001 << ls_addr[1:0];
        wdata_next = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        strb_next  = 4'b0011 << ls_addr[1:0];
        wdata_next = {2{ls_wdata[15:0]}};
      end
      2'b10: begin
        strb_next  = 4'b1111;
        wdata_next = ls_wdata;
      end
      default: begin
        strb_next  = 4'b0000;
        wdata_next = ls_wdata;
      end
    endcase
    if (!ls_we) strb_next = 4'b0000;
  end

  // Load extraction from the captured byte offset and size.
  always_comb begin
    shifted  = mem_rdata >> {offset_q, 3'b000};
    load_ext = 32'h0;
    case (funct3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_ext = shifted;
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = 32'h0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt;

  // Count consecutive REQ cycles without mem_ready; cleared outside REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= 16'h0;
    end else if (state != REQ) begin
      wait_cnt <= 16'h0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // mem_ready on the limit cycle takes priority, so only a no-ready cycle times out.
  assign timeout_hit = (state == REQ) && !mem_ready && ((wait_cnt + 16'd1) == TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
`endif

  // Access sequencer with registered bus and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      funct3_q  <= 3'b000;
      offset_q  <= 2'b00;
      fault_q   <= 1'b0;
      ls_rdata  <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wstrb <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (ls_valid && legal) begin
            funct3_q  <= ls_funct3;
            offset_q  <= ls_addr[1:0];
            fault_q   <= 1'b0;
            mem_we    <= ls_we;
            mem_addr  <= {ls_addr[31:2], 2'b00};
            mem_wstrb <= strb_next;
            mem_wdata <= wdata_next;
            mem_req   <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_ready) begin
            ls_rdata <= mem_we ? 32'h0 : load_ext;
            mem_req  <= 1'b0;
            state    <= DONE;
          end else if (timeout_hit) begin
            ls_rdata <= 32'h0;
            fault_q  <= 1'b1;
            mem_req  <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          // Result is presented for exactly one cycle; IDLE always shows zero.
          ls_rdata <= 32'h0;
          fault_q  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall and illegal-request fault are combinational so the core reacts in the same cycle.
  always_comb begin
    ls_stall = !reset && (((state == IDLE) && ls_valid && legal) || (state == REQ));
    ls_fault = !reset && (fault_q || ((state == IDLE) && ls_valid && !legal));
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a table of directed vectors, random
// accesses checked against an arithmetic reference model, and hand-written
// sequences for reset mid-access, stray mem_ready and (optionally) timeout.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid;
  logic        ls_we;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_stall;
  logic        ls_fault;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

`ifdef LSU_TIMEOUT_EN
  localparam int MAXW = 3;
`else
  localparam int MAXW = 5;
`endif

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ls_valid  (ls_valid),
    .ls_we     (ls_we),
    .ls_funct3 (ls_funct3),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_rdata  (ls_rdata),
    .ls_stall  (ls_stall),
    .ls_fault  (ls_fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        exp_fault;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                              input logic exp_fault, input logic [31:0] exp_rdata,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.waits = waits;
    v.exp_fault = exp_fault; v.exp_rdata = exp_rdata; v.exp_strb = exp_strb; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  // Reference model: access size in bytes, legality by divisibility, lane math by arithmetic.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
    vec_t v;
    int size;
    int o;
    longint val;
    longint span;
    v = mk(we, f3, addr, wdata, rdata, waits, 1'b0, 32'h0, 4'h0, 32'h0);
    o = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (we && f3 >= 3'd4) || (addr % size) != 0) begin
      v.exp_fault = 1'b1;
    end else if (we) begin
      v.exp_strb = 4'(((1 << size) - 1) << o);
      if (size == 1)      v.exp_wdata = wdata[7:0] * 32'h01010101;
      else if (size == 2) v.exp_wdata = wdata[15:0] * 32'h00010001;
      else                v.exp_wdata = wdata;
    end else begin
      span = longint'(1) << (8 * size);
      val  = (longint'(rdata) >> (8 * o)) % span;
      if (f3 < 3'd4 && size < 4 && val >= span / 2) val = val - span;
      v.exp_rdata = 32'(val);
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    ls_valid = 1'b1; ls_we = v.we; ls_funct3 = v.f3; ls_addr = v.addr; ls_wdata = v.wdata;
    mem_ready = 1'b0; mem_rdata = $urandom;
    #1;
    if (v.exp_fault) begin
      chk({tag, " idle_fault"}, {31'h0, ls_fault}, 32'h1);
      chk({tag, " idle_fault_stall"}, {31'h0, ls_stall}, 32'h0);
      chk({tag, " idle_fault_rdata"}, ls_rdata, 32'h0);
      @(negedge clk);
      ls_valid = 1'b0;
      #1;
      chk({tag, " no_bus_req"}, {31'h0, mem_req}, 32'h0);
      chk({tag, " fault_clears"}, {31'h0, ls_fault}, 32'h0);
      return;
    end
    chk({tag, " idle_stall"}, {31'h0, ls_stall}, 32'h1);
    chk({tag, " idle_fault"}, {31'h0, ls_fault}, 32'h0);
    chk({tag, " idle_req"}, {31'h0, mem_req}, 32'h0);
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge clk);
      ls_valid = 1'b0;
      ls_addr  = $urandom;
      ls_wdata = $urandom;
      chk({tag, " req"}, {31'h0, mem_req}, 32'h1);
      chk({tag, " req_stall"}, {31'h0, ls_stall}, 32'h1);
      chk({tag, " mem_addr"}, mem_addr, {v.addr[31:2], 2'b00});
      chk({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, v.we});
      chk({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, v.exp_strb});
      if (v.we) chk({tag, " mem_wdata"}, mem_wdata, v.exp_wdata);
      if (i == v.waits) begin
        mem_ready = 1'b1; mem_rdata = v.rdata;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom;
      end
    end
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = $urandom;
    ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h0;
    #1;
    chk({tag, " done_stall"}, {31'h0, ls_stall}, 32'h0);
    chk({tag, " done_req"}, {31'h0, mem_req}, 32'h0);
    chk({tag, " done_fault"}, {31'h0, ls_fault}, 32'h0);
    if (!v.we) chk({tag, " done_rdata"}, ls_rdata, v.exp_rdata);
    ls_valid = 1'b0;
    @(negedge clk);
    chk({tag, " back_idle_stall"}, {31'h0, ls_stall}, 32'h0);
    chk({tag, " back_idle_req"}, {31'h0, mem_req}, 32'h0);
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = mk(1'b0, 3'b010, 32'h100, 32'h0,        32'hCAFEBABE, 0,    1'b0, 32'hCAFEBABE, 4'h0,    32'h0);
    tbl[1]  = mk(1'b0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0,    1'b0, 32'hFFFFFF80, 4'h0,    32'h0);
    tbl[2]  = mk(1'b0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1,    1'b0, 32'h00000080, 4'h0,    32'h0);
    tbl[3]  = mk(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0,    1'b0, 32'h0,        4'b1100, 32'hABCDABCD);
    tbl[4]  = mk(1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        0,    1'b1, 32'h0,        4'h0,    32'h0);
    tbl[5]  = mk(1'b1, 3'b010, 32'h300, 32'hDEADBEEF, 32'h0,        MAXW, 1'b0, 32'h0,        4'b1111, 32'hDEADBEEF);
    tbl[6]  = mk(1'b0, 3'b001, 32'h402, 32'h0,        32'h80011234, 2,    1'b0, 32'hFFFF8001, 4'h0,    32'h0);
    tbl[7]  = mk(1'b0, 3'b101, 32'h402, 32'h0,        32'h80011234, 0,    1'b0, 32'h00008001, 4'h0,    32'h0);
    tbl[8]  = mk(1'b1, 3'b000, 32'h501, 32'h000000A5, 32'h0,        0,    1'b0, 32'h0,        4'b0010, 32'hA5A5A5A5);
    tbl[9]  = mk(1'b0, 3'b001, 32'h401, 32'h0,        32'h0,        0,    1'b1, 32'h0,        4'h0,    32'h0);
    tbl[10] = mk(1'b0, 3'b011, 32'h400, 32'h0,        32'h0,        0,    1'b1, 32'h0,        4'h0,    32'h0);
    tbl[11] = mk(1'b1, 3'b100, 32'h400, 32'h0,        32'h0,        0,    1'b1, 32'h0,        4'h0,    32'h0);
    tbl[12] = mk(1'b0, 3'b110, 32'h400, 32'h0,        32'h0,        0,    1'b1, 32'h0,        4'h0,    32'h0);
    tbl[13] = mk(1'b0, 3'b000, 32'h600, 32'h0,        32'h0000007F, 0,    1'b0, 32'h0000007F, 4'h0,    32'h0);

    // Reset with a legal request present: stall must stay low, registered outputs zero.
    reset = 1'b1; ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h100;
    ls_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst stall", {31'h0, ls_stall}, 32'h0);
    chk("rst fault", {31'h0, ls_fault}, 32'h0);
    chk("rst req", {31'h0, mem_req}, 32'h0);
    chk("rst rdata", ls_rdata, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst mem_we", {31'h0, mem_we}, 32'h0);
    ls_valid = 1'b0;
    reset = 1'b0;

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

    // Stray mem_ready in IDLE must not start anything.
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk("stray_ready req", {31'h0, mem_req}, 32'h0);
    chk("stray_ready rdata", ls_rdata, 32'h0);
    mem_ready = 1'b0;

    // Reset asserted mid-REQ drops mem_req before the next edge.
    @(negedge clk);
    ls_valid = 1'b1; ls_we = 1'b1; ls_funct3 = 3'b010; ls_addr = 32'h800; ls_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    ls_valid = 1'b0;
    chk("midrst req_before", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    #1;
    chk("midrst req_dropped", {31'h0, mem_req}, 32'h0);
    chk("midrst stall", {31'h0, ls_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst idle_req", {31'h0, mem_req}, 32'h0);
    chk("midrst idle_stall", {31'h0, ls_stall}, 32'h0);
    chk("midrst idle_fault", {31'h0, ls_fault}, 32'h0);

    // Recovery access after the abandoned one.
    run_vec(model(1'b0, 3'b010, 32'h804, 32'h0, 32'h0BADF00D, 0), "post_rst");

`ifdef LSU_TIMEOUT_EN
    // Ready stuck low: after 4 REQ cycles the access ends in DONE with a fault.
    @(negedge clk);
    ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b010; ls_addr = 32'h700;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ls_valid = 1'b0;
      chk("timeout req", {31'h0, mem_req}, 32'h1);
    end
    @(negedge clk);
    chk("timeout fault", {31'h0, ls_fault}, 32'h1);
    chk("timeout rdata", ls_rdata, 32'h0);
    chk("timeout req_low", {31'h0, mem_req}, 32'h0);
    chk("timeout stall", {31'h0, ls_stall}, 32'h0);
    @(negedge clk);
    chk("timeout fault_clears", {31'h0, ls_fault}, 32'h0);
    // mem_ready on the limit cycle wins.
    run_vec(model(1'b0, 3'b010, 32'h704, 32'h0, 32'h600DCAFE, 3), "ready_at_limit");
`endif

    // Random accesses against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
        else if (f3[1:0] == 2'b01) addr[0] = 1'b0;
      end
      run_vec(model(we, f3, addr, $urandom, $urandom, $urandom_range(0, MAXW)),
              $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
